alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It accepts one operation at a time over a valid/ready input port and returns a registered result with a flag set over a valid/ready output port. Multiply returns the full double-width product, and divide is iterative, one quotient bit per cycle. It sits between an operand-issue stage and a writeback stage that can apply backpressure.

## Interface
- `W`, 8: operand and result width, ≥4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when `in_valid && in_ready`.
- `a`, `b`  in  W  operands, unsigned except for the `ovf` flag.
- `sel`  in  4  opcode.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result when `out_valid && out_ready`.
- `result`  out  W  primary result.
- `result_hi`  out  W  product upper half (MUL) or remainder (DIV/REM); 0 for all other ops.
- `carry`  out  1  carry/borrow/overflow indicator, per op.
- `zero`  out  1  `{result_hi,result}` equals 0.
- `ovf`  out  1  signed two's-complement overflow, ADD/SUB only; 0 for all other ops.
- `err`  out  1  illegal opcode, or DIV/REM with the divider compiled out.

## Operation
Opcodes:
- 0 ADD: `carry` = bit W of the sum.
- 1 SUB: `carry` = borrow (`a<b`).
- 2 MUL: `carry` = `|result_hi`.
- 3 DIV: `result` = quotient.
- 4 AND.
- 5 OR.
- 6 NAND.
- 7 XOR.
- 8 NOT a.
- 9 NOR.
- 10 REM: `result` = remainder, `result_hi` = quotient.
- 11–15: illegal; `result` = 0, `err` = 1, `carry` = 0.

Division:
- DIV/REM with `b==0`: `result` = 0, `result_hi` = `a`, `carry` = 1, completes with single-cycle latency.
- Otherwise `carry` = 0.

State machine:
- IDLE –accept, divide op with b≠0→ BUSY.
- IDLE –accept, any other op→ DONE.
- BUSY –iteration counter reaches W−1→ DONE.
- DONE –`out_ready`, with no new accept in the same cycle→ IDLE.
- DONE –`out_ready` with a new accept in the same cycle→ BUSY or DONE, chosen by the new op.

Handshake and result rules:
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from `out_ready`.
- `out_valid` = (state==DONE).
- Outputs are stable while `out_valid && !out_ready`.
- Operands are captured on accept. `a`, `b` and `sel` are don't-care at all other times.
- Arithmetic is computed at W+1 bits for ADD/SUB and 2W bits for MUL. No truncation is permitted before the flags are derived.

Reset:
- While `rst_n`=0 at a clock edge: state→IDLE, iteration counter→0.
- `result`, `result_hi`, `carry`, `zero`, `ovf`, `err` all →0. `out_valid`=0 and `in_ready`=0 during reset.
- A reset in BUSY or DONE discards the operation; no result is ever emitted for it.

## Timing
- Non-divide ops, and divide with `b==0`: `out_valid` rises on the edge after the accept (latency 1).
- DIV/REM with `b≠0`: `out_valid` rises W+1 edges after the accept (latency 9 for W=8). The divider is restoring and produces one quotient bit per BUSY cycle, MSB first.
- Throughput:
  - Single-cycle ops sustain one op per cycle while `out_ready` is held at 1.
  - Divides sustain one op per W+1 cycles.
- Backpressure holds DONE indefinitely. No operation is accepted during BUSY.

## Configuration
- `ALU_SEQ_DIV_EN` defined: the iterative divider is instantiated and DIV/REM behave as above.
- `ALU_SEQ_DIV_EN` undefined:
  - The divider is not instantiated and the BUSY state is unreachable.
  - DIV/REM complete at latency 1 with `result` = 0, `result_hi` = 0, `carry` = 0, `err` = 1.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode enum (`OP_ADD`…`OP_REM`);
  - the state enum (IDLE/BUSY/DONE);
  - a packed flag struct {carry, zero, ovf, err}.
- Sub-module `alu_seq_div`, parametrised by W, instantiated only under `ALU_SEQ_DIV_EN`:
  - inputs: start, dividend, divisor;
  - outputs: quotient, remainder, done pulse.
- All other ops live in the top level as a single combinational case feeding the result registers.

## Test plan
- ADD 200+100, W=8 → `result`=44, `carry`=1, `ovf`=0, `out_valid` one cycle after accept.
- SUB 5−10 → `result`=251, `carry`=1. Then SUB 100−(−100)=100−156 → `result`=200, `ovf`=1.
- MUL 16×32 → `result`=0, `result_hi`=2, `carry`=1, `zero`=0. Then MUL 0×77 → `zero`=1.
- DIV 200/7 → `result`=28, `result_hi`=4, `out_valid` 9 cycles after accept, `in_ready`=0 throughout BUSY. DIV 9/0 → `result`=0, `carry`=1, latency 1.
- Back-to-back AND/OR/XOR, each in_valid in consecutive cycles with `out_ready`=1 → one result per cycle. With `out_ready`=0 for 5 cycles → outputs frozen, `in_ready`=0. Illegal `sel`=15 → `result`=0, `err`=1.
- `rst_n`=0 at cycle 4 of a DIV 255/3 → no `out_valid`, all outputs 0. The next op after release (ADD 1+1) returns 2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode/state enums and result flag struct for alu_seq.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_NAND = 4'd6,
      OP_XOR  = 4'd7,
      OP_NOT  = 4'd8,
      OP_NOR  = 4'd9,
      OP_REM  = 4'd10
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic ovf;
      logic err;
   } flags_t;

   function automatic logic is_div_op(input logic [3:0] sel);
      return (sel == OP_DIV) || (sel == OP_REM);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation issue / result return handshake bundle for alu_seq.
interface alu_seq_if #(parameter int W = 8);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry;
   logic         zero;
   logic         ovf;
   logic         err;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, result, result_hi, carry, zero, ovf, err
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, result, result_hi, carry, zero, ovf, err
   );

endinterface

// File: rtl/alu_seq_div.sv
// rtl/alu_seq_div.sv - restoring divider, one quotient bit per cycle MSB first.
// Instantiated by alu_seq only when ALU_SEQ_DIV_EN is defined; done_o pulses one cycle after the last bit.
module alu_seq_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] quotient_o,
   output logic [W-1:0] remainder_o,
   output logic         done_o
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  quo_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  dvs_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;

   logic [W:0]    part;
   logic          fits;
   logic [W-1:0]  trial;

   // Partial remainder needs W+1 bits before the trial subtract.
   always_comb begin
      part  = {rem_q, quo_q[W-1]};
      fits  = (part >= {1'b0, dvs_q});
      trial = part[W-1:0] - dvs_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            quo_q <= {quo_q[W-2:0], fits};
            rem_q <= fits ? trial : part[W-1:0];
            if (cnt_q == CW'(W - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign done_o      = done_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result, full-width multiply and optional divider.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV/REM report err.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_if.slave    bus
);

   state_e       state_q, state_d;
   logic [W-1:0] result_q, result_d;
   logic [W-1:0] hi_q, hi_d;
   flags_t       flags_q, flags_d;

   logic         accept;
   logic         start_div;
   logic         div_done;

   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [2*W-1:0] prod;
   logic [W-1:0]   res_c;
   logic [W-1:0]   hi_c;
   flags_t         flg_c;

   assign bus.in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
   assign bus.out_valid = rst_n && (state_q == DONE);
   assign accept        = bus.in_valid && bus.in_ready;

   // Single-cycle datapath; widened so carry/borrow/high product survive to the flags.
   always_comb begin
      sum   = {1'b0, bus.a} + {1'b0, bus.b};
      diff  = {1'b0, bus.a} - {1'b0, bus.b};
      prod  = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
      res_c = '0;
      hi_c  = '0;
      flg_c = '0;
      case (bus.sel)
         OP_ADD: begin
            res_c       = sum[W-1:0];
            flg_c.carry = sum[W];
            flg_c.ovf   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
         end
         OP_SUB: begin
            res_c       = diff[W-1:0];
            flg_c.carry = diff[W];
            flg_c.ovf   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
         end
         OP_MUL: begin
            res_c       = prod[W-1:0];
            hi_c        = prod[2*W-1:W];
            flg_c.carry = |prod[2*W-1:W];
         end
         OP_DIV, OP_REM: begin
`ifdef ALU_SEQ_DIV_EN
            if (bus.b == '0) begin
               hi_c        = bus.a;
               flg_c.carry = 1'b1;
            end
`else
            flg_c.err = 1'b1;
`endif
         end
         OP_AND:  res_c = bus.a & bus.b;
         OP_OR:   res_c = bus.a | bus.b;
         OP_NAND: res_c = ~(bus.a & bus.b);
         OP_XOR:  res_c = bus.a ^ bus.b;
         OP_NOT:  res_c = ~bus.a;
         OP_NOR:  res_c = ~(bus.a | bus.b);
         default: flg_c.err = 1'b1;
      endcase
      flg_c.zero = ({hi_c, res_c} == '0);
   end

`ifdef ALU_SEQ_DIV_EN
   logic [W-1:0] quo;
   logic [W-1:0] rem;
   logic         rem_op_q;

   assign start_div = accept && is_div_op(bus.sel) && (bus.b != '0);

   alu_seq_div #(.W(W)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_div),
      .dividend_i  (bus.a),
      .divisor_i   (bus.b),
      .quotient_o  (quo),
      .remainder_o (rem),
      .done_o      (div_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_op_q <= 1'b0;
      end else if (accept) begin
         rem_op_q <= (bus.sel == OP_REM);
      end
   end
`else
   assign start_div = 1'b0;
   assign div_done  = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      hi_d     = hi_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: if (accept) state_d = start_div ? BUSY : DONE;
         BUSY: if (div_done) state_d = DONE;
         DONE: begin
            if (bus.out_ready) begin
               state_d = accept ? (start_div ? BUSY : DONE) : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         result_d = res_c;
         hi_d     = hi_c;
         flags_d  = flg_c;
      end
`ifdef ALU_SEQ_DIV_EN
      if (div_done) begin
         result_d     = rem_op_q ? rem : quo;
         hi_d         = rem_op_q ? quo : rem;
         flags_d      = '0;
         flags_d.zero = (quo == '0) && (rem == '0);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         hi_q     <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.result_hi = hi_q;
   assign bus.carry     = flags_q.carry;
   assign bus.zero      = flags_q.zero;
   assign bus.ovf       = flags_q.ovf;
   assign bus.err       = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq; expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   lat;
   int   seen;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op1(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.sel       = s;
      bus.a         = x;
      bus.b         = y;
      #1;
      chk("in_ready_at_issue", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_lat(output int l);
      bus.out_ready = 1'b1;
      l = 1;
      while (bus.out_valid !== 1'b1 && l < 40) begin
         chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
         l++;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] h,
                          input logic c, input logic z, input logic o, input logic e);
      chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".result"},    {24'd0, bus.result},    {24'd0, r});
      chk({tag, ".result_hi"}, {24'd0, bus.result_hi}, {24'd0, h});
      chk({tag, ".carry"},     {31'd0, bus.carry},     {31'd0, c});
      chk({tag, ".zero"},      {31'd0, bus.zero},      {31'd0, z});
      chk({tag, ".ovf"},       {31'd0, bus.ovf},       {31'd0, o});
      chk({tag, ".err"},       {31'd0, bus.err},       {31'd0, e});
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.sel       = 4'd0;
      bus.a         = 8'd0;
      bus.b         = 8'd0;

      tick();
      tick();
      chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("rst.outputs", {12'd0, bus.result_hi, bus.result, bus.carry, bus.zero, bus.ovf, bus.err}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle.in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

      op1(OP_ADD, 8'd200, 8'd100);
      chk_out("add_200_100", 8'd44, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      op1(OP_SUB, 8'd5, 8'd10);
      chk_out("sub_5_10", 8'd251, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      op1(OP_SUB, 8'd100, 8'd156);
      chk_out("sub_100_156", 8'd200, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      op1(OP_MUL, 8'd16, 8'd32);
      chk_out("mul_16_32", 8'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      op1(OP_MUL, 8'd0, 8'd77);
      chk_out("mul_0_77", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      op1(OP_DIV, 8'd200, 8'd7);
      wait_lat(lat);
`ifdef ALU_SEQ_DIV_EN
      chk("div_200_7.latency", lat, 32'd9);
      chk_out("div_200_7", 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      op1(OP_REM, 8'd200, 8'd7);
      wait_lat(lat);
      chk("rem_200_7.latency", lat, 32'd9);
      chk_out("rem_200_7", 8'd4, 8'd28, 1'b0, 1'b0, 1'b0, 1'b0);
`else
      chk("div_200_7.latency", lat, 32'd1);
      chk_out("div_200_7", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

      op1(OP_DIV, 8'd9, 8'd0);
      wait_lat(lat);
      chk("div_9_0.latency", lat, 32'd1);
`ifdef ALU_SEQ_DIV_EN
      chk_out("div_9_0", 8'd0, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
`else
      chk_out("div_9_0", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

      // Back-to-back single-cycle ops with the consumer always ready.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 8'hCC;
      bus.b         = 8'hAA;
      bus.sel       = OP_AND;
      #1;
      chk("b2b.in_ready0", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk_out("b2b_and", 8'h88, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("b2b.in_ready1", {31'd0, bus.in_ready}, 32'd1);
      bus.sel = OP_OR;
      tick();
      chk_out("b2b_or", 8'hEE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.sel = OP_XOR;
      tick();
      chk_out("b2b_xor", 8'h66, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      bus.out_ready = 1'b0;
      bus.sel       = OP_ADD;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
         chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp.result", {24'd0, bus.result}, 32'h66);
      end
      bus.in_valid = 1'b0;

      op1(OP_NAND, 8'hCC, 8'hAA);
      chk_out("nand", 8'h77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      op1(OP_NOT, 8'hCC, 8'hAA);
      chk_out("not", 8'h33, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      op1(OP_NOR, 8'hCC, 8'hAA);
      chk_out("nor", 8'h11, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      op1(4'd15, 8'h12, 8'h34);
      chk_out("illegal_15", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a divide must discard it.
      op1(OP_DIV, 8'd255, 8'd3);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("mid_rst.outputs", {12'd0, bus.result_hi, bus.result, bus.carry, bus.zero, bus.ovf, bus.err}, 32'd0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      chk("post_rst.no_out_valid", seen, 32'd0);
      op1(OP_ADD, 8'd1, 8'd1);
      chk_out("post_rst_add_1_1", 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
